// File: rtl/amba_axi4_txn_monitor.sv
// Passive AXI4 transaction monitor: tracks write bursts, per-ID reads and outstanding
// counts, and latches sticky protocol-violation flags for sim, formal and silicon debug.
module amba_axi4_txn_monitor #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int MAXWAIT         = 16,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     ERR_CLR,
    input  logic                     AWVALID,
    input  logic                     AWREADY,
    input  logic [ADDRESS_WIDTH-1:0] AWADDR,
    input  logic [ID_WIDTH-1:0]      AWID,
    input  logic [7:0]               AWLEN,
    input  logic                     WVALID,
    input  logic                     WREADY,
    input  logic                     WLAST,
    input  logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ID_WIDTH-1:0]      BID,
    input  logic [1:0]               BRESP,
    input  logic                     ARVALID,
    input  logic                     ARREADY,
    input  logic [ADDRESS_WIDTH-1:0] ARADDR,
    input  logic [ID_WIDTH-1:0]      ARID,
    input  logic [7:0]               ARLEN,
    input  logic                     RVALID,
    input  logic                     RREADY,
    input  logic                     RLAST,
    input  logic [ID_WIDTH-1:0]      RID,
    output logic [9:0]               ERR,
    output logic                     ERR_ANY,
    output logic [CW-1:0]            AW_PENDING,
    output logic [CW-1:0]            B_PENDING,
    output logic [CW-1:0]            AR_PENDING
);

    localparam int NUM_IDS = 2 ** ID_WIDTH;
    localparam int PW      = $clog2(MAX_OUTSTANDING);
    localparam int TW      = $clog2(MAXWAIT + 1);
    localparam int NCH     = 5;

    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] WAIT_LIMIT = TW'(MAXWAIT);
    localparam logic [TW-1:0] WAIT_PRE   = TW'(MAXWAIT - 1);

    localparam int E_AW_STABLE     = 0;
    localparam int E_AR_STABLE     = 1;
    localparam int E_WLAST_EARLY   = 2;
    localparam int E_WLAST_MISSING = 3;
    localparam int E_W_NO_AW       = 4;
    localparam int E_B_NO_TXN      = 5;
    localparam int E_R_NO_TXN      = 6;
    localparam int E_OVF           = 7;
    localparam int E_TIMEOUT       = 8;
    localparam int E_RESET_VALID   = 9;

    logic [7:0]               lenMem_q [MAX_OUTSTANDING];
    logic [PW-1:0]            wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]            fifoCount_q, fifoCount_d;
    logic [8:0]               beatCount_q, beatCount_d;
    logic [CW-1:0]            bPending_q, bPending_d;
    logic [CW-1:0]            arPending_q, arPending_d;
    logic [CW-1:0]            idCount_q [NUM_IDS];
    logic [CW-1:0]            idCount_d [NUM_IDS];
    logic [TW-1:0]            stall_q [NCH];
    logic [TW-1:0]            stall_d [NCH];
    logic                     awStall_q, arStall_q;
    logic [ADDRESS_WIDTH-1:0] awAddr_q, arAddr_q;
    logic [ID_WIDTH-1:0]      awId_q, arId_q;
    logic [7:0]               awLen_q, arLen_q;
    logic                     firstEdge_q;
    logic [9:0]               err_q, err_d, errSet;
    logic                     errAny_q;

    logic awHs, wHs, bHs, arHs, rHs;
    logic fifoEmpty, fifoFull, awPush, wTracked, wFinal;
    logic arInc, rDec, bDec;
    logic [7:0] headLen;
    logic [NCH-1:0] chanValid, chanReady, timeoutHit;
    logic unusedBits;

    assign unusedBits = ^{BID, BRESP};

    assign chanValid = {RVALID, ARVALID, BVALID, WVALID, AWVALID};
    assign chanReady = {RREADY, ARREADY, BREADY, WREADY, AWREADY};

    // An empty FIFO with a same-cycle AW push lets the W beat see the incoming AWLEN.
    always_comb begin
        awHs      = AWVALID && AWREADY;
        wHs       = WVALID && WREADY;
        bHs       = BVALID && BREADY;
        arHs      = ARVALID && ARREADY;
        rHs       = RVALID && RREADY;
        fifoEmpty = (fifoCount_q == '0);
        fifoFull  = (fifoCount_q == MAX_CNT);
        awPush    = awHs && !fifoFull;
        wTracked  = wHs && (!fifoEmpty || awPush);
        headLen   = fifoEmpty ? AWLEN : lenMem_q[rdPtr_q];
        wFinal    = wTracked && (beatCount_q == {1'b0, headLen});
        arInc     = arHs && (arPending_q != MAX_CNT);
        rDec      = rHs && RLAST && (idCount_q[RID] != '0);
        bDec      = bHs && (bPending_q != '0);
    end

    always_comb begin
        wrPtr_d     = awPush ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d     = wFinal ? rdPtr_q + PW'(1) : rdPtr_q;
        fifoCount_d = fifoCount_q;
        if (awPush && !wFinal) begin
            fifoCount_d = fifoCount_q + CW'(1);
        end else if (!awPush && wFinal) begin
            fifoCount_d = fifoCount_q - CW'(1);
        end

        beatCount_d = beatCount_q;
        if (wFinal) begin
            beatCount_d = '0;
        end else if (wTracked) begin
            beatCount_d = beatCount_q + 9'd1;
        end

        // B_PENDING has no architectural bound, so it saturates rather than wraps.
        bPending_d = bPending_q;
        if (wFinal && !bDec) begin
            if (bPending_q != '1) begin
                bPending_d = bPending_q + CW'(1);
            end
        end else if (!wFinal && bDec) begin
            bPending_d = bPending_q - CW'(1);
        end

        arPending_d = arPending_q;
        if (arInc && !rDec) begin
            arPending_d = arPending_q + CW'(1);
        end else if (!arInc && rDec) begin
            arPending_d = arPending_q - CW'(1);
        end

        for (int i = 0; i < NUM_IDS; i++) begin
            idCount_d[i] = idCount_q[i];
            if (arInc && (ARID == ID_WIDTH'(i)) && !(rDec && (RID == ID_WIDTH'(i)))) begin
                idCount_d[i] = idCount_q[i] + CW'(1);
            end else if (!(arInc && (ARID == ID_WIDTH'(i))) && rDec && (RID == ID_WIDTH'(i))) begin
                idCount_d[i] = idCount_q[i] - CW'(1);
            end
        end

        for (int c = 0; c < NCH; c++) begin
            stall_d[c]    = '0;
            timeoutHit[c] = 1'b0;
            if (chanValid[c] && !chanReady[c]) begin
                timeoutHit[c] = (stall_q[c] == WAIT_PRE);
                stall_d[c]    = (stall_q[c] == WAIT_LIMIT) ? stall_q[c] : stall_q[c] + TW'(1);
            end
        end
    end

    always_comb begin
        errSet                  = '0;
        errSet[E_AW_STABLE]     = awStall_q && (!AWVALID || (AWADDR != awAddr_q) ||
                                                (AWID != awId_q) || (AWLEN != awLen_q));
        errSet[E_AR_STABLE]     = arStall_q && (!ARVALID || (ARADDR != arAddr_q) ||
                                                (ARID != arId_q) || (ARLEN != arLen_q));
        errSet[E_WLAST_EARLY]   = wTracked && !wFinal && WLAST;
        errSet[E_WLAST_MISSING] = wFinal && !WLAST;
        errSet[E_W_NO_AW]       = wHs && !wTracked;
        errSet[E_B_NO_TXN]      = bHs && (bPending_q == '0);
        errSet[E_R_NO_TXN]      = rHs && (idCount_q[RID] == '0);
        errSet[E_OVF]           = (awHs && fifoFull) || (arHs && (arPending_q == MAX_CNT));
        errSet[E_TIMEOUT]       = |timeoutHit;
        errSet[E_RESET_VALID]   = firstEdge_q && (|chanValid);
        err_d                   = (ERR_CLR ? 10'd0 : err_q) | errSet;
    end

    always_ff @(posedge ACLK) begin
        if (awPush) begin
            lenMem_q[wrPtr_q] <= AWLEN;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
            beatCount_q <= '0;
            bPending_q  <= '0;
            arPending_q <= '0;
            for (int i = 0; i < NUM_IDS; i++) begin
                idCount_q[i] <= '0;
            end
            for (int c = 0; c < NCH; c++) begin
                stall_q[c] <= '0;
            end
            awStall_q   <= 1'b0;
            arStall_q   <= 1'b0;
            awAddr_q    <= '0;
            arAddr_q    <= '0;
            awId_q      <= '0;
            arId_q      <= '0;
            awLen_q     <= '0;
            arLen_q     <= '0;
            firstEdge_q <= 1'b1;
            err_q       <= '0;
            errAny_q    <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            fifoCount_q <= fifoCount_d;
            beatCount_q <= beatCount_d;
            bPending_q  <= bPending_d;
            arPending_q <= arPending_d;
            for (int i = 0; i < NUM_IDS; i++) begin
                idCount_q[i] <= idCount_d[i];
            end
            for (int c = 0; c < NCH; c++) begin
                stall_q[c] <= stall_d[c];
            end
            awStall_q   <= AWVALID && !AWREADY;
            arStall_q   <= ARVALID && !ARREADY;
            awAddr_q    <= AWADDR;
            arAddr_q    <= ARADDR;
            awId_q      <= AWID;
            arId_q      <= ARID;
            awLen_q     <= AWLEN;
            arLen_q     <= ARLEN;
            firstEdge_q <= 1'b0;
            err_q       <= err_d;
            errAny_q    <= |err_q;
        end
    end

    assign ERR        = err_q;
    assign ERR_ANY    = errAny_q;
    assign AW_PENDING = fifoCount_q;
    assign B_PENDING  = bPending_q;
    assign AR_PENDING = arPending_q;

endmodule

// File: tb/tb_amba_axi4_txn_monitor.sv
// Bench for amba_axi4_txn_monitor: directed protocol scenarios followed by random traffic,
// every cycle compared against a queue-based reference model of the monitor's rules.
module tb_amba_axi4_txn_monitor;

    localparam int ADDRESS_WIDTH   = 32;
    localparam int ID_WIDTH        = 4;
    localparam int MAX_OUTSTANDING = 8;
    localparam int MAXWAIT         = 16;
    localparam int CW              = 4;
    localparam int NUM_IDS         = 16;
    localparam int B_SAT           = 15;

    logic                     ACLK, ARESETn, ERR_CLR;
    logic                     AWVALID, AWREADY, WVALID, WREADY, WLAST;
    logic                     BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [ADDRESS_WIDTH-1:0] AWADDR, ARADDR;
    logic [ID_WIDTH-1:0]      AWID, BID, ARID, RID;
    logic [7:0]               AWLEN, ARLEN;
    logic [1:0]               BRESP;
    logic [9:0]               ERR;
    logic                     ERR_ANY;
    logic [CW-1:0]            AW_PENDING, B_PENDING, AR_PENDING;

    int checks   = 0;
    int failures = 0;

    int                       mLen[$];
    int                       mBeat, mB, mAr;
    int                       mId[NUM_IDS];
    int                       mStall[5];
    bit                       mAwStall, mArStall, mFirst, mErrAny;
    logic [ADDRESS_WIDTH-1:0] mAwAddr, mArAddr;
    logic [ID_WIDTH-1:0]      mAwId, mArId;
    logic [7:0]               mAwLen, mArLen;
    logic [9:0]               mErr;

    amba_axi4_txn_monitor #(
        .ADDRESS_WIDTH  (ADDRESS_WIDTH),
        .ID_WIDTH       (ID_WIDTH),
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .MAXWAIT        (MAXWAIT)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .ERR_CLR   (ERR_CLR),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .AWADDR    (AWADDR),
        .AWID      (AWID),
        .AWLEN     (AWLEN),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .WLAST     (WLAST),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARADDR    (ARADDR),
        .ARID      (ARID),
        .ARLEN     (ARLEN),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RLAST     (RLAST),
        .RID       (RID),
        .ERR       (ERR),
        .ERR_ANY   (ERR_ANY),
        .AW_PENDING(AW_PENDING),
        .B_PENDING (B_PENDING),
        .AR_PENDING(AR_PENDING)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        ERR_CLR = 1'b0;
        AWVALID = 1'b0; AWREADY = 1'b0; AWADDR = '0; AWID = '0; AWLEN = '0;
        WVALID  = 1'b0; WREADY  = 1'b0; WLAST  = 1'b0;
        BVALID  = 1'b0; BREADY  = 1'b0; BID    = '0; BRESP = '0;
        ARVALID = 1'b0; ARREADY = 1'b0; ARADDR = '0; ARID = '0; ARLEN = '0;
        RVALID  = 1'b0; RREADY  = 1'b0; RLAST  = 1'b0; RID  = '0;
    endtask

    task automatic modelReset();
        mLen.delete();
        mBeat = 0; mB = 0; mAr = 0;
        for (int i = 0; i < NUM_IDS; i++) mId[i] = 0;
        for (int c = 0; c < 5; c++) mStall[c] = 0;
        mAwStall = 0; mArStall = 0; mFirst = 1; mErrAny = 0;
        mAwAddr = '0; mArAddr = '0; mAwId = '0; mArId = '0; mAwLen = '0; mArLen = '0;
        mErr = '0;
    endtask

    // Rules applied to the inputs present at the coming rising edge.
    task automatic modelStep();
        logic [9:0] set;
        logic [4:0] vv, rr;
        int         bOld, arOld;
        int         idOld[NUM_IDS];
        bit         done;
        set   = '0;
        vv    = {RVALID, ARVALID, BVALID, WVALID, AWVALID};
        rr    = {RREADY, ARREADY, BREADY, WREADY, AWREADY};
        bOld  = mB;
        arOld = mAr;
        idOld = mId;
        done  = 0;

        if (mAwStall && (!AWVALID || AWADDR !== mAwAddr || AWID !== mAwId || AWLEN !== mAwLen)) set[0] = 1'b1;
        if (mArStall && (!ARVALID || ARADDR !== mArAddr || ARID !== mArId || ARLEN !== mArLen)) set[1] = 1'b1;

        if (AWVALID && AWREADY) begin
            if (mLen.size() == MAX_OUTSTANDING) set[7] = 1'b1;
            else mLen.push_back(int'(AWLEN));
        end
        if (WVALID && WREADY) begin
            if (mLen.size() == 0) set[4] = 1'b1;
            else if (mBeat == mLen[0]) begin
                done = 1;
                if (!WLAST) set[3] = 1'b1;
                void'(mLen.pop_front());
                mBeat = 0;
            end else begin
                if (WLAST) set[2] = 1'b1;
                mBeat++;
            end
        end

        if (BVALID && BREADY && bOld == 0) set[5] = 1'b1;
        if (done && !(BVALID && BREADY && bOld > 0)) mB = (bOld < B_SAT) ? bOld + 1 : bOld;
        else if (!done && BVALID && BREADY && bOld > 0) mB = bOld - 1;

        if (ARVALID && ARREADY) begin
            if (arOld == MAX_OUTSTANDING) set[7] = 1'b1;
            else begin
                mAr++;
                mId[ARID]++;
            end
        end
        if (RVALID && RREADY) begin
            if (idOld[RID] == 0) set[6] = 1'b1;
            else if (RLAST) begin
                mAr--;
                mId[RID]--;
            end
        end

        for (int c = 0; c < 5; c++) begin
            if (vv[c] && !rr[c]) begin
                if (mStall[c] == MAXWAIT - 1) set[8] = 1'b1;
                if (mStall[c] < MAXWAIT) mStall[c]++;
            end else begin
                mStall[c] = 0;
            end
        end
        if (mFirst && (|vv)) set[9] = 1'b1;
        mFirst = 0;

        mAwStall = AWVALID && !AWREADY;
        mArStall = ARVALID && !ARREADY;
        mAwAddr = AWADDR; mAwId = AWID; mAwLen = AWLEN;
        mArAddr = ARADDR; mArId = ARID; mArLen = ARLEN;
        mErrAny = |mErr;
        mErr    = (ERR_CLR ? 10'd0 : mErr) | set;
    endtask

    // One clock edge with the current inputs, then compare every output against the model.
    task automatic applyStimulus();
        modelStep();
        @(posedge ACLK);
        #1;
        checkOutput("err", 32'(ERR), 32'(mErr));
        checkOutput("err_any", 32'(ERR_ANY), 32'(mErrAny));
        checkOutput("aw_pending", 32'(AW_PENDING), 32'(mLen.size()));
        checkOutput("b_pending", 32'(B_PENDING), 32'(mB));
        checkOutput("ar_pending", 32'(AR_PENDING), 32'(mAr));
    endtask

    task automatic applyReset();
        ARESETn = 1'b0;
        modelReset();
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    initial begin
        idleInputs();
        ARESETn = 1'b1;
        #2;
        applyReset();
        checkOutput("reset_err", 32'(ERR), 32'h0);
        checkOutput("reset_aw_pending", 32'(AW_PENDING), 32'h0);
        applyStimulus();

        $display("[TB] write burst AW(ID3,LEN3), 4 W beats, B");
        AWVALID = 1; AWREADY = 1; AWID = 4'd3; AWLEN = 8'd3; AWADDR = 32'h100;
        applyStimulus();
        checkOutput("t1_aw_pending_after_aw", 32'(AW_PENDING), 32'd1);
        AWVALID = 0; AWREADY = 0;
        for (int beat = 1; beat <= 4; beat++) begin
            WVALID = 1; WREADY = 1; WLAST = (beat == 4);
            applyStimulus();
            if (beat == 3) checkOutput("t1_aw_pending_beat3", 32'(AW_PENDING), 32'd1);
        end
        checkOutput("t1_aw_pending_beat4", 32'(AW_PENDING), 32'd0);
        checkOutput("t1_b_pending_beat4", 32'(B_PENDING), 32'd1);
        WVALID = 0; WREADY = 0; WLAST = 0;
        BVALID = 1; BREADY = 1;
        applyStimulus();
        checkOutput("t1_b_pending_after_b", 32'(B_PENDING), 32'd0);
        checkOutput("t1_err_clean", 32'(ERR), 32'h0);
        BVALID = 0; BREADY = 0;

        $display("[TB] early WLAST then missing WLAST via bypass");
        AWVALID = 1; AWREADY = 1; AWLEN = 8'd3;
        applyStimulus();
        AWVALID = 0; AWREADY = 0;
        for (int beat = 1; beat <= 4; beat++) begin
            WVALID = 1; WREADY = 1; WLAST = (beat == 2) || (beat == 4);
            applyStimulus();
            if (beat == 2) checkOutput("t2_wlast_early", 32'(ERR), 32'h004);
        end
        AWVALID = 1; AWREADY = 1; AWLEN = 8'd0; WVALID = 1; WREADY = 1; WLAST = 0;
        applyStimulus();
        checkOutput("t2_wlast_missing", 32'(ERR), 32'h00C);
        checkOutput("t2_bypass_aw_pending", 32'(AW_PENDING), 32'd0);
        checkOutput("t2_bypass_b_pending", 32'(B_PENDING), 32'd2);
        idleInputs();

        $display("[TB] read outstanding overflow and per-ID checks");
        applyReset();
        applyStimulus();
        ARVALID = 1; ARREADY = 1; ARID = 4'd5; ARLEN = 8'd1;
        for (int n = 1; n <= 9; n++) begin
            ARADDR = 32'(n * 64);
            applyStimulus();
            if (n == 8) checkOutput("t3_ar_pending_full", 32'(AR_PENDING), 32'd8);
        end
        checkOutput("t3_ovf", 32'(ERR), 32'h080);
        checkOutput("t3_ar_pending_stays", 32'(AR_PENDING), 32'd8);
        ARVALID = 0; ARREADY = 0;
        RVALID = 1; RREADY = 1; RID = 4'd5; RLAST = 1;
        applyStimulus();
        checkOutput("t3_ar_pending_after_r", 32'(AR_PENDING), 32'd7);
        RID = 4'd2;
        applyStimulus();
        checkOutput("t3_r_no_txn", 32'(ERR), 32'h0C0);
        idleInputs();

        $display("[TB] AW stall with address change, timeout, clear");
        applyReset();
        applyStimulus();
        AWVALID = 1; AWREADY = 0; AWADDR = 32'h1000; AWID = 4'd1; AWLEN = 8'd2;
        for (int c = 1; c <= 16; c++) begin
            if (c == 5) AWADDR = 32'h2000;
            applyStimulus();
            if (c == 4)  checkOutput("t4_stable_before", 32'(ERR), 32'h000);
            if (c == 5)  checkOutput("t4_aw_stable", 32'(ERR), 32'h001);
            if (c == 15) checkOutput("t4_no_timeout_yet", 32'(ERR), 32'h001);
        end
        checkOutput("t4_timeout", 32'(ERR), 32'h101);
        AWREADY = 1; ERR_CLR = 1;
        applyStimulus();
        checkOutput("t4_err_cleared", 32'(ERR), 32'h000);
        checkOutput("t4_err_any_lags", 32'(ERR_ANY), 32'd1);
        AWVALID = 0; AWREADY = 0; ERR_CLR = 0;
        applyStimulus();
        checkOutput("t4_err_any_cleared", 32'(ERR_ANY), 32'd0);
        idleInputs();

        $display("[TB] VALID at reset release, B without transaction");
        WVALID = 1;
        applyReset();
        applyStimulus();
        checkOutput("t5_reset_valid", 32'(ERR), 32'h200);
        checkOutput("t5_err_any_not_yet", 32'(ERR_ANY), 32'd0);
        WVALID = 0;
        BVALID = 1; BREADY = 1;
        applyStimulus();
        checkOutput("t5_b_no_txn", 32'(ERR), 32'h220);
        checkOutput("t5_b_pending_zero", 32'(B_PENDING), 32'd0);
        checkOutput("t5_err_any", 32'(ERR_ANY), 32'd1);
        idleInputs();

        $display("[TB] asynchronous reset mid-burst");
        applyReset();
        applyStimulus();
        AWVALID = 1; AWREADY = 1; AWLEN = 8'd1;
        applyStimulus();
        applyStimulus();
        checkOutput("t6_aw_pending_two", 32'(AW_PENDING), 32'd2);
        AWVALID = 0; AWREADY = 0; WVALID = 1; WREADY = 1; WLAST = 0;
        applyStimulus();
        #2;
        ARESETn = 0;
        modelReset();
        #1;
        checkOutput("t6_async_err", 32'(ERR), 32'h0);
        checkOutput("t6_async_err_any", 32'(ERR_ANY), 32'h0);
        checkOutput("t6_async_aw_pending", 32'(AW_PENDING), 32'h0);
        checkOutput("t6_async_b_pending", 32'(B_PENDING), 32'h0);
        checkOutput("t6_async_ar_pending", 32'(AR_PENDING), 32'h0);
        idleInputs();
        @(negedge ACLK);
        ARESETn = 1;
        applyStimulus();
        AWVALID = 1; AWREADY = 1; AWLEN = 8'd1;
        applyStimulus();
        AWVALID = 0; AWREADY = 0;
        WVALID = 1; WREADY = 1; WLAST = 0;
        applyStimulus();
        WLAST = 1;
        applyStimulus();
        WVALID = 0; WREADY = 0; WLAST = 0; BVALID = 1; BREADY = 1;
        applyStimulus();
        checkOutput("t6_clean_err", 32'(ERR), 32'h0);
        checkOutput("t6_clean_b_pending", 32'(B_PENDING), 32'd0);
        idleInputs();

        $display("[TB] random traffic");
        applyReset();
        applyStimulus();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!(AWVALID && !AWREADY) || $urandom_range(0, 7) == 0) begin
                AWADDR  = $urandom;
                AWID    = 4'($urandom_range(0, 3));
                AWLEN   = 8'($urandom_range(0, 3));
                AWVALID = 1'($urandom_range(0, 1));
            end
            if (!(ARVALID && !ARREADY) || $urandom_range(0, 7) == 0) begin
                ARADDR  = $urandom;
                ARID    = 4'($urandom_range(0, 3));
                ARLEN   = 8'($urandom_range(0, 3));
                ARVALID = 1'($urandom_range(0, 1));
            end
            AWREADY = 1'($urandom_range(0, 1));
            ARREADY = 1'($urandom_range(0, 1));
            WVALID  = 1'($urandom_range(0, 1));
            WREADY  = 1'($urandom_range(0, 2) != 0);
            WLAST   = 1'($urandom_range(0, 2) == 0);
            BVALID  = 1'($urandom_range(0, 1));
            BREADY  = 1'($urandom_range(0, 3) != 0);
            BID     = 4'($urandom_range(0, 15));
            BRESP   = 2'($urandom_range(0, 3));
            RVALID  = 1'($urandom_range(0, 1));
            RREADY  = 1'($urandom_range(0, 1));
            RLAST   = 1'($urandom_range(0, 1));
            RID     = 4'($urandom_range(0, 3));
            ERR_CLR = 1'($urandom_range(0, 5) == 0);
            applyStimulus();
        end
        idleInputs();
        applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
